// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Streams a program image into instruction memory. Receives bytes
//             over a valid/ready handshake, packs each LO/HI byte pair into one
//             9-bit instruction, writes it through a single memory write port,
//             and holds the CPU in reset until the whole image is written.
//  Options  : `define CHECKSUM_EN adds a trailing XOR checksum byte and an
//             error state; without it err is constant 0.
//  Ports    :
//    clk          in   system clock, rising edge
//    reset        in   asynchronous active-low reset
//    start        in   one-cycle load request (honoured in IDLE/DONE/ERR)
//    rx_data      in   [7:0] stream byte
//    rx_valid     in   rx_data is valid
//    rx_ready     out  loader accepts a byte this cycle
//    imem_we      out  instruction memory write enable
//    imem_addr    out  [ADDR_W-1:0]  write address
//    imem_wdata   out  [INSTR_W-1:0] write data
//    cpu_hold     out  keeps the CPU in reset while high
//    busy         out  load in progress
//    done         out  load completed successfully
//    err          out  checksum failure
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 9,
  parameter int START_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Remaining-instruction counter must represent 256 (length byte of 0).
  localparam int CNT_W = 9;
  localparam logic [ADDR_W-1:0] C_START = ADDR_W'(START_ADDR);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_CHK   = 3'd6,
    S_ERR   = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           lo_q, lo_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 we_q, we_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 w_accept;
`ifdef CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
  logic                 err_q, err_d;
`endif

  assign w_accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
`ifdef CHECKSUM_EN
    xor_d   = xor_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = C_START;
`ifdef CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      S_LEN: begin
        if (w_accept) begin
          // A length byte of 0 encodes a full 256-instruction image.
          cnt_d   = (rx_data == 8'h00) ? CNT_W'(256) : {1'b0, rx_data};
          state_d = S_LO;
`ifdef CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      S_LO: begin
        if (w_accept) begin
          lo_d    = rx_data;
          state_d = S_HI;
`ifdef CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      S_HI: begin
        if (w_accept) begin
          // Only bit 0 of the HI byte carries instruction data.
          wdata_d = INSTR_W'({rx_data[0], lo_q});
          state_d = S_WRITE;
`ifdef CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LO;
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          state_d = ((xor_q ^ rx_data) == 8'h00) ? S_DONE : S_ERR;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = C_START;
          xor_d   = 8'h00;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the next state.
    rx_ready_d = (state_d == S_LEN) || (state_d == S_LO) || (state_d == S_HI)
`ifdef CHECKSUM_EN
                 || (state_d == S_CHK)
`endif
                 ;
    we_d   = (state_d == S_WRITE);
    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LEN) || (state_d == S_LO) || (state_d == S_HI)
             || (state_d == S_WRITE)
`ifdef CHECKSUM_EN
             || (state_d == S_CHK)
`endif
             ;
`ifdef CHECKSUM_EN
    err_d  = (state_d == S_ERR);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= C_START;
      cnt_q      <= '0;
      lo_q       <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CHECKSUM_EN
      xor_q      <= xor_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader. Table of single-instruction
//             loads, hand-written multi-cycle sequences, and randomized images
//             checked against a byte-stream reference model.
//  Options  : honours `define CHECKSUM_EN to match the design build.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] a;
    logic [8:0] d;
    int         c;
  } wr_t;
  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [8:0] imem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  wr_t wq[$];
  wr_t exp_q[$];

  prog_loader #(.ADDR_W(8), .INSTR_W(9), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with imem_we high is one write; a stretched pulse shows up
  // as an extra entry.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t w;
      w.a = imem_addr;
      w.d = imem_wdata;
      w.c = cyc;
      wq.push_back(w);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the index of the clock edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output int edge_no);
    int t;
    edge_no = -1;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        edge_no = cyc + 1;
        tick();
        rx_valid = 1'b0;
        break;
      end
      t++;
      if (t > 50) begin
        chk("byte_accept_timeout", 32'd1, 32'd0);
        tick();
        rx_valid = 1'b0;
        break;
      end
    end
  endtask

  // Reference: image layout is LEN, then LO/HI pairs, then (optionally)
  // a checksum making the XOR of the whole stream zero.
  task automatic build_model(input bq_t prog, output bit ok);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = (prog[0] == 8'h00) ? 256 : int'(prog[0]);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      logic [7:0] lo;
      logic [7:0] hi;
      lo  = prog[1 + 2 * i];
      hi  = prog[2 + 2 * i];
      w.a = 8'((0 + i) % 256);
      w.d = {hi[0], lo};
      w.c = 0;
      exp_q.push_back(w);
    end
    x = 8'h00;
    foreach (prog[i]) x = x ^ prog[i];
`ifdef CHECKSUM_EN
    ok = (x == 8'h00);
`else
    ok = 1'b1;
`endif
  endtask

  task automatic run_load(input bq_t prog, input int gmode, input int mid_idx, input string tag);
    int e;
    int hi_e[$];
    bit ok;
    int n;
    int w;
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_after_start"}, done, 0);
    chk({tag, "_hold_after_start"}, cpu_hold, 1);
    n = (prog[0] == 8'h00) ? 256 : int'(prog[0]);
    for (int i = 0; i < prog.size(); i++) begin
      int g;
      if (i == mid_idx) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      g = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(prog[i], g, e);
      if (i >= 2 && (i % 2) == 0 && i <= 2 * n) hi_e.push_back(e);
    end
    w = 0;
    while (!(done === 1'b1 || err === 1'b1) && w < 20) begin
      tick();
      w++;
    end
    repeat (3) tick();
    build_model(prog, ok);
    chk({tag, "_write_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), wq[i].a, exp_q[i].a);
      chk($sformatf("%s_data[%0d]", tag, i), wq[i].d, exp_q[i].d);
      chk($sformatf("%s_lat[%0d]", tag, i), wq[i].c, (i < hi_e.size()) ? hi_e[i] : -1);
    end
    chk({tag, "_done"}, done, ok);
    chk({tag, "_err"}, err, !ok);
    chk({tag, "_cpu_hold"}, cpu_hold, !ok);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_rx_ready_end"}, rx_ready, 0);
  endtask

  function automatic bq_t with_sum(input bq_t p);
    bq_t r;
    logic [7:0] x;
    r = p;
`ifdef CHECKSUM_EN
    x = 8'h00;
    foreach (p[i]) x = x ^ p[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  initial begin
    vec_t tbl[5];
    bq_t  p;
    int   w;

    tbl[0] = '{lo: 8'h34, hi: 8'h01, exp: 9'h134};
    tbl[1] = '{lo: 8'hFF, hi: 8'hFE, exp: 9'h0FF};
    tbl[2] = '{lo: 8'h00, hi: 8'hFF, exp: 9'h100};
    tbl[3] = '{lo: 8'hAB, hi: 8'h00, exp: 9'h0AB};
    tbl[4] = '{lo: 8'h5A, hi: 8'h03, exp: 9'h15A};

    // Reset values, then idle without start.
    #12;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_hold", cpu_hold, 1);
    chk("idle_rx_ready", rx_ready, 0);
    chk("idle_we", imem_we, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_writes", wq.size(), 0);

    // Basic load, back to back.
    p = '{8'h02, 8'h34, 8'h01, 8'hAB, 8'h00};
    run_load(with_sum(p), 0, -1, "basic");

    // Valid toggling and a start pulse mid-load that must be ignored.
    run_load(with_sum(p), 1, 3, "gaps");

    // Table of single-instruction loads with hand-computed data words.
    for (int i = 0; i < 5; i++) begin
      p = '{8'h01, tbl[i].lo, tbl[i].hi};
      run_load(with_sum(p), 0, -1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_const", i), (wq.size() > 0) ? wq[0].d : 9'h1FF, tbl[i].exp);
    end

    // Full 256-instruction image wrapping the address space.
    p.delete();
    p.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      p.push_back(8'(i));
      p.push_back(8'($urandom));
    end
    run_load(with_sum(p), 0, -1, "wrap");
    chk("wrap_last_addr", (wq.size() > 0) ? wq[wq.size() - 1].a : 8'h00, 8'hFF);

    // Reset asserted asynchronously after the first write.
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int e;
      send_byte(8'h02, 0, e);
      send_byte(8'h34, 0, e);
      send_byte(8'h01, 0, e);
    end
    w = 0;
    while (wq.size() == 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("mid_first_write_seen", wq.size(), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    tick();
    reset = 1'b1;
    tick();
    p = '{8'h01, 8'h77, 8'h01};
    run_load(with_sum(p), 0, -1, "after_rst");

`ifdef CHECKSUM_EN
    p = '{8'h01, 8'h5A, 8'h01, 8'h5A};
    run_load(p, 0, -1, "cks_good");
    chk("cks_good_data", (wq.size() > 0) ? wq[0].d : 9'h000, 9'h15A);
    chk("cks_good_done_const", done, 1);
    p = '{8'h01, 8'h5A, 8'h01, 8'h00};
    run_load(p, 0, -1, "cks_bad");
    chk("cks_bad_data", (wq.size() > 0) ? wq[0].d : 9'h000, 9'h15A);
    chk("cks_bad_err_const", err, 1);
    chk("cks_bad_hold_const", cpu_hold, 1);
`endif

    // Randomized images with random handshake gaps.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = int'($urandom_range(1, 6));
      p.delete();
      p.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) p.push_back(8'($urandom));
      p = with_sum(p);
`ifdef CHECKSUM_EN
      if ((it % 3) == 2) p[p.size() - 1] = p[p.size() - 1] ^ 8'(1 + $urandom_range(0, 254));
`endif
      run_load(p, 2, -1, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the CPU's instruction fetch path.
- Receives a program as a byte stream over a valid/ready handshake and assembles each pair of bytes into one 9-bit instruction.
- Writes each instruction into instruction memory through a single write port.
- Holds the CPU in reset (cpu_hold) until the whole image is written, then releases it.

Parameters:
- ADDR_W, 8, instruction memory address width; equals PC width.
- INSTR_W, 9, instruction width.
- START_ADDR, 0, address of the first instruction written.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- cpu_hold  output  1  high keeps the CPU in reset.
- busy  output  1  a load is in progress.
- done  output  1  load completed successfully.
- err  output  1  checksum failure; tied 0 unless CHECKSUM_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters and data registers cleared.
  - Outputs: rx_ready=0, imem_we=0, imem_addr=START_ADDR, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
  - Reset asserted mid-load aborts immediately; memory contents already written are left as is.
- Byte transfer: a byte is accepted only on a cycle with rx_valid=1 and rx_ready=1. rx_ready is a registered function of state: 1 in LEN, LO, HI, CHK; 0 elsewhere.
- States and transitions:
  - IDLE: start=1 -> LEN; busy=1 and done=0 from the next cycle.
  - LEN: accepted byte -> count N. N=0 means 256 instructions. Go to LO.
  - LO: accepted byte -> instruction bits [7:0]. Go to HI.
  - HI: accepted byte; bit 0 -> instruction bit [8]; bits [7:1] are ignored. Go to WRITE.
  - WRITE: exactly one cycle. imem_we=1, imem_addr=current address, imem_wdata={hi[0],lo}, rx_ready=0.
    - Next cycle: address increments by 1 and remaining count decrements.
    - If remaining count is 0 after this write -> CHK when CHECKSUM_EN is defined, otherwise DONE. Else -> LO.
  - DONE: busy=0, done=1, cpu_hold=0. start=1 -> LEN: done=0 and cpu_hold=1 from the next cycle; address reloads to START_ADDR.
  - ERR: only exists when CHECKSUM_EN is defined. busy=0, err=1, cpu_hold=1. Only start (restart) or reset leaves ERR.
- cpu_hold=1 in every state except DONE.
- Latency: HI byte accepted at edge k -> imem_we high during cycle k+1. Minimum 3 cycles per instruction.
- Address arithmetic is modulo 2^ADDR_W. With START_ADDR=0 and N=0, the last write is to address 255. No write occurs past the N-th instruction.
- A start pulse while busy=1 is ignored; no restart, no state change.
- When rx_valid=0 the FSM waits indefinitely in the current state; no timeout.
- imem_addr and imem_wdata are registered and may hold stale values while imem_we=0.

Optional Feature:
- Macro: CHECKSUM_EN.
- When defined:
  - A running 8-bit XOR covers every accepted byte: LEN, every LO and every HI byte.
  - After the last WRITE the FSM enters CHK and accepts one more byte.
  - If (running XOR ^ byte) == 0 -> DONE; otherwise -> ERR.
  - The XOR accumulator clears on every start.
- When not defined:
  - There is no CHK or ERR state and no checksum byte.
  - err is constant 0 and is driven 0 out of reset.

Test Plan:
- Reset then idle: hold reset=0, release, wait 10 cycles with no start -> cpu_hold=1, rx_ready=0, imem_we=0, busy=0, done=0.
- Basic load: start, then stream 02, 34, 01, AB, 00 with rx_valid always 1 -> writes at addr 0 data 0x134, at addr 1 data 0x0AB. Each imem_we is a single cycle, one cycle after its HI byte is accepted. Then done=1 and cpu_hold=0.
- Backpressure and gaps: same stream with rx_valid toggling 1/0 each cycle, plus a start pulse mid-load -> identical writes and final state; the mid-load start is ignored.
- Full wrap: N=00 followed by 256 instruction pairs -> 256 writes at addresses 0..255, with no extra write afterwards; then done=1.
- Reset mid-load: reset=0 asynchronously after the first WRITE -> outputs return to reset values within the reset cycle. A subsequent start and 1-instruction load completes normally.
- CHECKSUM_EN, two cases:
  - Stream 01, 5A, 01 followed by checksum 5A -> done=1.
  - Same stream with checksum 00 -> err=1, cpu_hold stays 1, done=0.
  - In both cases the write at addr 0 is data 0x15A.
